excp_commit: RTL and testbench

- Producer side of the CSR exception write port. Sits at WB.
- Decides interrupt, exception and ertn commit from WB status and current CSR fields.
- Builds the CSR update (crmd/prmd/estat/era/badv), drives pipeline flush and PC redirect.
- Samples interrupt lines and keeps estat.is coherent.

---
 rtl/excp_commit_pkg.sv | 37 +++
 rtl/excp_timer.sv | 57 +++++
 rtl/excp_commit.sv | 205 ++++++++++++++++++++
 tb/tb_excp_commit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/excp_commit_pkg.sv
// Shared constants and types for the WB exception commit block: ecodes, estat.is
// bit positions, timer config bit positions, FSM/commit encodings.
package excp_commit_pkg;

    localparam int FLUSH_CYC_DEF = 2;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    localparam int IS_HWI_LO = 2;
    localparam int IS_TI     = 11;
    localparam int IS_IPI    = 12;

    localparam int TMR_EN_BIT  = 0;
    localparam int TMR_PER_BIT = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        CM_NONE,
        CM_INT,
        CM_EXC,
        CM_ERTN
    } commit_t;

    // TLB refill exceptions vector to their own entry point.
    function automatic logic [31:0] excp_target(input logic [5:0]  ecode,
                                                input logic [31:0] eentry,
                                                input logic [31:0] tlbrentry);
        return (ecode == ECODE_TLBR) ? tlbrentry : eentry;
    endfunction

endpackage

// File: rtl/excp_timer.sv
// Interval timer feeding estat.is[11]; only built when TIMER_EN is defined.
// Config word: {initval[W-1:2], periodic, en}; loads {initval, 2'b00}.
`ifdef TIMER_EN
module excp_timer
    import excp_commit_pkg::*;
#(
    parameter int TIMER_WID = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [TIMER_WID-1:0] cfg,
    input  logic                 clr,
    output logic [TIMER_WID-1:0] val,
    output logic                 ti
);

    logic [TIMER_WID-1:0] cnt_reg;
    logic [TIMER_WID-1:0] reload_reg;
    logic                 en_reg;
    logic                 per_reg;
    logic                 ti_reg;
    logic                 expire;

    assign expire = !cfg_we && en_reg && (cnt_reg == TIMER_WID'(1));
    assign val    = cnt_reg;
    assign ti     = ti_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            reload_reg <= '0;
            en_reg     <= 1'b0;
            per_reg    <= 1'b0;
            ti_reg     <= 1'b0;
        end else begin
            if (cfg_we) begin
                reload_reg <= {cfg[TIMER_WID-1:2], 2'b00};
                cnt_reg    <= {cfg[TIMER_WID-1:2], 2'b00};
                en_reg     <= cfg[TMR_EN_BIT];
                per_reg    <= cfg[TMR_PER_BIT];
            end else if (en_reg && cnt_reg != '0) begin
                // One-shot parks at zero; periodic goes straight back to the reload value.
                if (expire)
                    cnt_reg <= per_reg ? reload_reg : '0;
                else
                    cnt_reg <= cnt_reg - TIMER_WID'(1);
            end
            if (clr)
                ti_reg <= 1'b0;
            else if (expire)
                ti_reg <= 1'b1;
        end
    end

endmodule
`endif

// File: rtl/excp_commit.sv
// WB-stage commit of interrupts/exceptions/ertn into the CSR exception write port,
// plus flush/redirect and estat.is upkeep. Define TIMER_EN to add the interval timer.
module excp_commit
    import excp_commit_pkg::*;
#(
    parameter int FLUSH_CYC = FLUSH_CYC_DEF
`ifdef TIMER_EN
    ,
    parameter int TIMER_WID = 32
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic        wb_excp,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic        wb_badv_we,
    input  logic [31:0] wb_badv,
    input  logic        wb_ertn,
    input  logic        csr_inst_we,
    input  logic        tlb_we,
    input  logic [7:0]  hwi,
    input  logic        ipi,
`ifdef TIMER_EN
    input  logic                 tmr_cfg_we,
    input  logic [TIMER_WID-1:0] tmr_cfg,
    input  logic                 tmr_clr,
    output logic [TIMER_WID-1:0] tmr_val,
`endif
    input  logic [1:0]  csr_plv,
    input  logic        csr_ie,
    input  logic [1:0]  csr_pplv,
    input  logic        csr_pie,
    input  logic [12:0] csr_lie,
    input  logic [12:0] csr_is,
    input  logic [1:0]  csr_swi,
    input  logic [31:0] csr_era,
    input  logic [31:0] csr_badv,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_tlbrentry,
    output logic        excp_we,
    output logic [1:0]  wr_plv,
    output logic        wr_ie,
    output logic [1:0]  wr_pplv,
    output logic        wr_pie,
    output logic [5:0]  wr_ecode,
    output logic [8:0]  wr_esubcode,
    output logic [12:0] wr_is,
    output logic [31:0] wr_era,
    output logic [31:0] wr_badv,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam int CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [7:0]         hwi_s1, hwi_s2;
    logic               ti;
    logic [12:0]        is_s;
    commit_t            commit;
    logic               is_upd;
    logic               we_next, ie_next, pie_next;
    logic [1:0]         plv_next, pplv_next;
    logic [5:0]         ecode_next;
    logic [8:0]         esubcode_next;
    logic [31:0]        era_next, badv_next, rpc_next;

`ifdef TIMER_EN
    excp_timer #(.TIMER_WID(TIMER_WID)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .cfg_we (tmr_cfg_we),
        .cfg    (tmr_cfg),
        .clr    (tmr_clr),
        .val    (tmr_val),
        .ti     (ti)
    );
`else
    assign ti = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hwi_s1 <= '0;
            hwi_s2 <= '0;
        end else begin
            hwi_s1 <= hwi;
            hwi_s2 <= hwi_s1;
        end
    end

    always_comb begin
        is_s                  = '0;
        is_s[1:0]             = csr_swi;
        is_s[IS_HWI_LO +: 8]  = hwi_s2;
        is_s[IS_TI]           = ti;
        is_s[IS_IPI]          = ipi;
    end

    always_comb begin
        commit = CM_NONE;
        if (state_reg == ST_IDLE && wb_valid) begin
            if (csr_ie && |(csr_is & csr_lie))
                commit = CM_INT;
            else if (wb_excp)
                commit = CM_EXC;
            else if (wb_ertn)
                commit = CM_ERTN;
        end
    end

    // Another CSR writer this cycle would lose to the exception port, so hold off.
    assign is_upd = (is_s[12:2] != csr_is[12:2]) && !csr_inst_we && !tlb_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= (state_reg == ST_FLUSH) ? cnt_reg + CNT_W'(1) : '0;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (commit != CM_NONE) state_next = ST_FLUSH;
            ST_FLUSH: if (cnt_reg == CNT_W'(FLUSH_CYC - 1)) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        we_next       = (commit != CM_NONE) || is_upd;
        plv_next      = csr_plv;
        ie_next       = csr_ie;
        pplv_next     = csr_pplv;
        pie_next      = csr_pie;
        ecode_next    = wr_ecode;
        esubcode_next = wr_esubcode;
        era_next      = csr_era;
        badv_next     = csr_badv;
        rpc_next      = redirect_pc;
        case (commit)
            CM_INT, CM_EXC: begin
                pplv_next     = csr_plv;
                pie_next      = csr_ie;
                plv_next      = 2'd0;
                ie_next       = 1'b0;
                era_next      = wb_pc;
                if (wb_badv_we) badv_next = wb_badv;
                ecode_next    = (commit == CM_INT) ? ECODE_INT : wb_ecode;
                esubcode_next = (commit == CM_INT) ? 9'd0 : wb_esubcode;
                rpc_next      = excp_target(ecode_next, csr_eentry, csr_tlbrentry);
            end
            CM_ERTN: begin
                plv_next = csr_pplv;
                ie_next  = csr_pie;
                rpc_next = csr_era;
            end
            default: ;
        endcase
    end

    assign flush = (state_reg == ST_FLUSH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            excp_we        <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            wr_plv         <= '0;
            wr_ie          <= 1'b0;
            wr_pplv        <= '0;
            wr_pie         <= 1'b0;
            wr_ecode       <= '0;
            wr_esubcode    <= '0;
            wr_is          <= '0;
            wr_era         <= '0;
            wr_badv        <= '0;
        end else begin
            excp_we        <= we_next;
            redirect_valid <= (commit != CM_NONE);
            if (commit != CM_NONE) redirect_pc <= rpc_next;
            if (we_next) begin
                wr_plv      <= plv_next;
                wr_ie       <= ie_next;
                wr_pplv     <= pplv_next;
                wr_pie      <= pie_next;
                wr_ecode    <= ecode_next;
                wr_esubcode <= esubcode_next;
                wr_is       <= is_s;
                wr_era      <= era_next;
                wr_badv     <= badv_next;
            end
        end
    end

endmodule

// File: tb/tb_excp_commit.sv
// Self-checking bench for excp_commit: directed scenarios then random traffic,
// compared each cycle against a behavioural model of the commit rules.
module tb_excp_commit;
    import excp_commit_pkg::*;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid, wb_excp, wb_badv_we, wb_ertn, csr_inst_we, tlb_we, ipi;
    logic [31:0] wb_pc, wb_badv;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [7:0]  hwi;
    logic [1:0]  csr_plv, csr_pplv, csr_swi;
    logic        csr_ie, csr_pie;
    logic [12:0] csr_lie, csr_is;
    logic [31:0] csr_era, csr_badv, csr_eentry, csr_tlbrentry;
    logic        excp_we, wr_ie, wr_pie, flush, redirect_valid;
    logic [1:0]  wr_plv, wr_pplv;
    logic [5:0]  wr_ecode;
    logic [8:0]  wr_esubcode;
    logic [12:0] wr_is;
    logic [31:0] wr_era, wr_badv, redirect_pc;
`ifdef TIMER_EN
    logic        tmr_cfg_we, tmr_clr;
    logic [31:0] tmr_cfg, tmr_val;
`endif

    always #5 clk = ~clk;

    excp_commit #(.FLUSH_CYC(FC)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_excp(wb_excp), .wb_ecode(wb_ecode),
        .wb_esubcode(wb_esubcode), .wb_badv_we(wb_badv_we), .wb_badv(wb_badv),
        .wb_ertn(wb_ertn), .csr_inst_we(csr_inst_we), .tlb_we(tlb_we), .hwi(hwi), .ipi(ipi),
`ifdef TIMER_EN
        .tmr_cfg_we(tmr_cfg_we), .tmr_cfg(tmr_cfg), .tmr_clr(tmr_clr), .tmr_val(tmr_val),
`endif
        .csr_plv(csr_plv), .csr_ie(csr_ie), .csr_pplv(csr_pplv), .csr_pie(csr_pie),
        .csr_lie(csr_lie), .csr_is(csr_is), .csr_swi(csr_swi), .csr_era(csr_era),
        .csr_badv(csr_badv), .csr_eentry(csr_eentry), .csr_tlbrentry(csr_tlbrentry),
        .excp_we(excp_we), .wr_plv(wr_plv), .wr_ie(wr_ie), .wr_pplv(wr_pplv), .wr_pie(wr_pie),
        .wr_ecode(wr_ecode), .wr_esubcode(wr_esubcode), .wr_is(wr_is), .wr_era(wr_era),
        .wr_badv(wr_badv), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_step = 0;

    // Reference model state: expected port values and cycles of flush still to show.
    int          flush_left;
    logic [7:0]  hwi_q[$];
    logic        e_we, e_rv, e_ie, e_pie;
    logic [1:0]  e_plv, e_pplv;
    logic [5:0]  e_ecode;
    logic [8:0]  e_esub;
    logic [12:0] e_is;
    logic [31:0] e_era, e_badv, e_rpc;
    logic        m_ti;
`ifdef TIMER_EN
    logic [31:0] m_tcnt, m_tload;
    logic        m_ten, m_tper;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        flush_left = 0;
        hwi_q = {8'h00, 8'h00};
        {e_we, e_rv, e_ie, e_pie, e_plv, e_pplv} = '0;
        e_ecode = '0; e_esub = '0; e_is = '0;
        e_era = '0; e_badv = '0; e_rpc = '0;
        m_ti = 1'b0;
`ifdef TIMER_EN
        m_tcnt = '0; m_tload = '0; m_ten = 1'b0; m_tper = 1'b0;
`endif
    endtask

    task automatic check_all();
        chk("excp_we", excp_we, e_we);
        chk("redirect_valid", redirect_valid, e_rv);
        chk("flush", flush, flush_left > 0);
        chk("wr_plv", wr_plv, e_plv);
        chk("wr_ie", wr_ie, e_ie);
        chk("wr_pplv", wr_pplv, e_pplv);
        chk("wr_pie", wr_pie, e_pie);
        chk("wr_ecode", wr_ecode, e_ecode);
        chk("wr_esubcode", wr_esubcode, e_esub);
        chk("wr_is", wr_is, e_is);
        chk("wr_era", wr_era, e_era);
        chk("wr_badv", wr_badv, e_badv);
        chk("redirect_pc", redirect_pc, e_rpc);
`ifdef TIMER_EN
        chk("tmr_val", tmr_val, m_tcnt);
`endif
    endtask

    // Predict the effect of the coming clock edge from the current inputs, then check.
    task automatic step();
        logic [12:0] is_now;
        int          kind;
        logic        upd;
        logic        expire;
        is_now = {ipi, m_ti, 1'b0, hwi_q[0], csr_swi};
        kind = 0;
        if (flush_left > 0) begin
            flush_left--;
        end else if (wb_valid) begin
            if (csr_ie && (csr_is & csr_lie) != 13'd0) kind = 1;
            else if (wb_excp) kind = 2;
            else if (wb_ertn) kind = 3;
        end
        upd  = (is_now[12:2] != csr_is[12:2]) && !csr_inst_we && !tlb_we;
        e_we = (kind != 0) || upd;
        e_rv = (kind != 0);
        if (e_we) begin
            e_is = is_now;
            e_plv = csr_plv; e_ie = csr_ie; e_pplv = csr_pplv; e_pie = csr_pie;
            e_era = csr_era; e_badv = csr_badv;
        end
        if (kind == 1 || kind == 2) begin
            e_pplv = csr_plv; e_pie = csr_ie; e_plv = 2'd0; e_ie = 1'b0;
            e_era = wb_pc;
            e_badv = wb_badv_we ? wb_badv : csr_badv;
            e_ecode = (kind == 1) ? 6'h00 : wb_ecode;
            e_esub = (kind == 1) ? 9'h000 : wb_esubcode;
            e_rpc = (e_ecode == 6'h3F) ? csr_tlbrentry : csr_eentry;
            flush_left = FC;
        end else if (kind == 3) begin
            e_plv = csr_pplv; e_ie = csr_pie;
            e_rpc = csr_era;
            flush_left = FC;
        end
        expire = 1'b0;
`ifdef TIMER_EN
        if (tmr_cfg_we) begin
            m_tload = {tmr_cfg[31:2], 2'b00};
            m_tcnt = m_tload; m_ten = tmr_cfg[0]; m_tper = tmr_cfg[1];
        end else if (m_ten && m_tcnt != 0) begin
            m_tcnt = m_tcnt - 1;
            if (m_tcnt == 0) begin
                expire = 1'b1;
                if (m_tper) m_tcnt = m_tload;
            end
        end
        if (tmr_clr) m_ti = 1'b0;
        else if (expire) m_ti = 1'b1;
`endif
        hwi_q.push_back(hwi);
        void'(hwi_q.pop_front());
        @(posedge clk);
        #1;
        n_step++;
        $display("step %0d kind=%0d we=%0b rv=%0b flush=%0b rpc=%h is=%h x=%0b",
                 n_step, kind, excp_we, redirect_valid, flush, redirect_pc, wr_is, expire);
        check_all();
    endtask

    task automatic quiet_wb();
        wb_valid = 0; wb_excp = 0; wb_ertn = 0; wb_badv_we = 0;
    endtask

    initial begin
        rst_n = 0;
        quiet_wb();
        wb_pc = 0; wb_badv = 0; wb_ecode = 0; wb_esubcode = 0;
        csr_inst_we = 0; tlb_we = 0; hwi = 0; ipi = 0;
        csr_plv = 0; csr_ie = 0; csr_pplv = 0; csr_pie = 0; csr_lie = 0; csr_is = 0;
        csr_swi = 0; csr_era = 0; csr_badv = 32'h0000_1234;
        csr_eentry = 32'h1c00_8000; csr_tlbrentry = 32'h1c00_f000;
`ifdef TIMER_EN
        tmr_cfg_we = 0; tmr_cfg = 0; tmr_clr = 0;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst_n = 1;

        // Exception commit, then two quiet cycles of flush.
        csr_plv = 2'd3; csr_ie = 1'b1;
        wb_valid = 1; wb_excp = 1; wb_ecode = ECODE_SYS; wb_esubcode = 9'h005;
        wb_pc = 32'h1c00_0100;
        step();
        chk("t1_prmd", {wr_pplv, wr_pie}, {2'd3, 1'b1});
        chk("t1_era", wr_era, 32'h1c00_0100);
        quiet_wb();
        step(); step(); step();

        // TLB refill with badv; a second exception arriving during flush is dropped.
        wb_valid = 1; wb_excp = 1; wb_ecode = 6'h3F; wb_esubcode = 0;
        wb_badv_we = 1; wb_badv = 32'hdead_0000; wb_pc = 32'h1c00_0140;
        step();
        chk("t2_rpc", redirect_pc, 32'h1c00_f000);
        chk("t2_badv", wr_badv, 32'hdead_0000);
        wb_ecode = 6'h01; wb_pc = 32'h1c00_0144;
        step(); step();
        quiet_wb();
        step();

        // ertn restores plv/ie from prmd and returns to era.
        csr_plv = 0; csr_ie = 0; csr_pplv = 2'd3; csr_pie = 1; csr_era = 32'h1c00_0200;
        wb_valid = 1; wb_ertn = 1; wb_pc = 32'h1c00_0300;
        step();
        chk("t3_plv", {wr_plv, wr_ie}, {2'd3, 1'b1});
        chk("t3_ecode", wr_ecode, 6'h3F);
        quiet_wb();
        step(); step();

        // hwi[0] through the synchronizer, then an interrupt commit.
        csr_ie = 1; csr_lie = 13'h004; hwi = 8'h01;
        step(); step(); step();
        csr_is = 13'h004;
        step();
        wb_valid = 1; wb_pc = 32'h1c00_0400;
        step();
        chk("t4_int_ecode", wr_ecode, 6'h00);
        quiet_wb();
        step(); step();

        // Same edge while another CSR writer is busy: the is update waits.
        csr_inst_we = 1; hwi = 8'h03;
        repeat (5) step();
        csr_inst_we = 0;
        step();
        csr_is = 13'h00c;
        step();

`ifdef TIMER_EN
        // One-shot timer of 8, then a clear colliding with expiry.
        csr_lie = 0; csr_ie = 0;
        tmr_cfg_we = 1; tmr_cfg = 32'h0000_0009;
        step();
        tmr_cfg_we = 0;
        repeat (8) step();
        chk("tmr_zero", tmr_val, 32'd0);
        csr_is = 13'h80c;
        repeat (3) step();
        chk("tmr_stop", tmr_val, 32'd0);
        tmr_clr = 1;
        step();
        tmr_clr = 0; csr_is = 13'h00c;
        tmr_cfg_we = 1;
        step();
        tmr_cfg_we = 0;
        repeat (7) step();
        tmr_clr = 1;
        step();
        tmr_clr = 0;
        repeat (2) step();
`endif

        // Reset while flushing drops flush and the strobes without waiting for a clock.
        wb_valid = 1; wb_excp = 1; wb_ecode = 6'h08; wb_pc = 32'h1c00_0500;
        step();
        quiet_wb();
        #2 rst_n = 0;
        #1;
        model_reset();
        chk("rst_flush", flush, 1'b0);
        chk("rst_rv", redirect_valid, 1'b0);
        chk("rst_we", excp_we, 1'b0);
        hwi = 0; csr_is = 0;
        @(posedge clk);
        #1 rst_n = 1;
        step();

        // Random traffic.
        for (int i = 0; i < 250; i++) begin
            wb_valid = 1'($urandom_range(0, 1));
            wb_excp = ($urandom_range(0, 2) == 0);
            wb_ertn = ($urandom_range(0, 2) == 0);
            wb_ecode = ($urandom_range(0, 3) == 0) ? 6'h3F : 6'($urandom);
            wb_esubcode = 9'($urandom);
            wb_badv_we = 1'($urandom_range(0, 1));
            wb_badv = $urandom; wb_pc = $urandom;
            csr_inst_we = ($urandom_range(0, 3) == 0);
            tlb_we = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) hwi = 8'($urandom);
            if ($urandom_range(0, 7) == 0) ipi = 1'($urandom);
            csr_plv = 2'($urandom); csr_ie = 1'($urandom); csr_pplv = 2'($urandom);
            csr_pie = 1'($urandom); csr_swi = 2'($urandom);
            csr_lie = 13'($urandom) & 13'h1fff;
            csr_is = ($urandom_range(0, 1) == 0) ? e_is : 13'($urandom) & 13'h1003;
            csr_era = $urandom; csr_badv = $urandom;
            csr_eentry = $urandom; csr_tlbrentry = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
